// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit/receive path.
//   - Default frame geometry (NB_DATA, TICKS_PER_BIT, SB_TICK, NB_TICK_CNT).
//   - COUNTER_LIMIT: baud_rate divisor, 50 MHz / 163 ~= 16 x 19200 baud.
//   - tx_state_e: transmitter FSM state encoding. ST_PARITY is only
//     reachable when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int NB_DATA_DEF       = 8;
    localparam int TICKS_PER_BIT_DEF = 16;
    localparam int SB_TICK_DEF       = 16;
    localparam int NB_TICK_CNT_DEF   = 5;
    localparam int COUNTER_LIMIT     = 163;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: request/status bundle between core logic and uart_tx.
//   tx_start  core -> tx   transmit request (honoured only while idle)
//   data      core -> tx   byte to send, latched at acceptance
//   tx        tx -> pin    serial line, idle high
//   busy      tx -> core   frame in progress
//   tx_done   tx -> core   one-cycle pulse at end of frame
// master: core side; slave: transmitter side.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
);

    logic               tx_start;
    logic [NB_DATA-1:0] data;
    logic               tx;
    logic               busy;
    logic               tx_done;

    modport master (
        output tx_start,
        output data,
        input  tx,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  data,
        output tx,
        output busy,
        output tx_done
    );

endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts oversampling ticks and flags the last tick of a
// bit period.
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_tick          one-cycle oversampling tick
//   i_clear         hold the counter at zero (transmitter idle)
//   i_limit         tick index of the last tick in the current bit (period-1)
//   o_bit_end       high on the tick that completes the bit; counter wraps
// o_bit_end is combinational so the FSM can act on the very tick that ends
// the bit; the FSM registers everything it drives off-chip.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int NB_TICK_CNT = NB_TICK_CNT_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_tick,
    input  logic                   i_clear,
    input  logic [NB_TICK_CNT-1:0] i_limit,
    output logic                   o_bit_end
);

    logic [NB_TICK_CNT-1:0] cnt_r;

    // A tick arriving while cleared (idle/accept cycle) is deliberately not counted.
    assign o_bit_end = i_tick & ~i_clear & (cnt_r == i_limit);

    // Tick counter: advances only on ticks, wraps at the end of each bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r <= {NB_TICK_CNT{1'b0}};
        end else if (i_clear || o_bit_end) begin
            cnt_r <= {NB_TICK_CNT{1'b0}};
        end else if (i_tick) begin
            cnt_r <= cnt_r + NB_TICK_CNT'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends one frame per accepted request:
// start bit (0), NB_DATA data bits LSB first, optional even-parity bit,
// stop bit (1). Bit timing from the 16x oversampling tick of baud_rate.
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset; abandons any frame in flight
//   i_tick   oversampling tick
//   bus      uart_tx_if.slave: tx_start, data in; tx, busy, tx_done out
// Optional feature: define UART_PARITY_EN to compile in the PARITY state
// (even parity over the latched byte). Without it DATA goes straight to STOP.
// bus.data must be NB_DATA wide (instantiate uart_tx_if with the same NB_DATA).
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA       = NB_DATA_DEF,
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int SB_TICK       = SB_TICK_DEF,
    parameter int NB_TICK_CNT   = NB_TICK_CNT_DEF
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_tick,
    uart_tx_if.slave  bus
);

    localparam int NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [NB_TICK_CNT-1:0] BIT_LIMIT  = NB_TICK_CNT'(TICKS_PER_BIT - 1);
    localparam logic [NB_TICK_CNT-1:0] STOP_LIMIT = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_BIT_CNT-1:0]  LAST_BIT   = NB_BIT_CNT'(NB_DATA - 1);

    tx_state_e              state_r,   state_s;
    logic [NB_DATA-1:0]     shift_r,   shift_s;
    logic [NB_BIT_CNT-1:0]  bit_cnt_r, bit_cnt_s;
    logic                   tx_r,      tx_s;
    logic                   busy_r,    busy_s;
    logic                   done_r,    done_s;
    logic                   bit_end_s;
    logic                   timer_clear_s;
    logic [NB_TICK_CNT-1:0] timer_limit_s;

`ifdef UART_PARITY_EN
    logic                   parity_r,  parity_s;

    function automatic logic even_parity(input logic [NB_DATA-1:0] d);
        even_parity = ^d;
    endfunction
`endif

    // Counter held at zero while idle, so the tick of the accept cycle is not counted.
    assign timer_clear_s = (state_r == ST_IDLE);

    // Stop bit may be longer than the other bits.
    assign timer_limit_s = (state_r == ST_STOP) ? STOP_LIMIT : BIT_LIMIT;

    uart_tx_bit_timer #(
        .NB_TICK_CNT (NB_TICK_CNT)
    ) u_bit_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_tick    (i_tick),
        .i_clear   (timer_clear_s),
        .i_limit   (timer_limit_s),
        .o_bit_end (bit_end_s)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        done_s    = 1'b0;
`ifdef UART_PARITY_EN
        parity_s  = parity_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    state_s   = ST_START;
                    shift_s   = bus.data;
                    bit_cnt_s = {NB_BIT_CNT{1'b0}};
`ifdef UART_PARITY_EN
                    parity_s  = even_parity(bus.data);
`endif
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_s = {1'b0, shift_r[NB_DATA-1:1]};
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_s = {NB_BIT_CNT{1'b0}};
`ifdef UART_PARITY_EN
                        state_s   = ST_PARITY;
`else
                        state_s   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + NB_BIT_CNT'(1);
                        state_s   = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered, so it appears one
        // cycle after the deciding edge together with busy.
        case (state_s)
            ST_IDLE:   tx_s = 1'b1;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shift_s[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_s = parity_s;
`endif
            ST_STOP:   tx_s = 1'b1;
            default:   tx_s = 1'b1;
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= {NB_DATA{1'b0}};
            bit_cnt_r <= {NB_BIT_CNT{1'b0}};
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            tx_r      <= tx_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
`ifdef UART_PARITY_EN
            parity_r  <= parity_s;
`endif
        end
    end

    assign bus.tx      = tx_r;
    assign bus.busy    = busy_r;
    assign bus.tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Stimulus pushes each byte that
// should appear on the line; a negedge monitor collects the line level on
// every tick of a frame and, on tx_done, compares it against the frame
// expected from the byte (start 0, data LSB first, optional even parity,
// stop 1, each bit 16 ticks).
module tb_uart_tx;
    import uart_pkg::*;

`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int TPB = 16;

    typedef struct {
        logic [7:0] d;
        bit         timed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    int   div = 4;
    int   tcnt = 0;

    int tests = 0;
    int fails = 0;

    exp_t sb_q[$];
    logic samples[$];
    bit   in_frame = 1'b0;
    int   busy_cycles = 0;
    logic prev_done = 1'b0;

    uart_tx_if #(.NB_DATA(8)) bus ();

    uart_tx #(
        .NB_DATA       (8),
        .TICKS_PER_BIT (16),
        .SB_TICK       (16),
        .NB_TICK_CNT   (5)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_tick  (tick),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Free-running baud tick, one pulse every div cycles.
    always @(posedge clk) begin
        if (tcnt >= div - 1) begin
            tcnt <= 0;
            tick <= 1'b1;
        end else begin
            tcnt <= tcnt + 1;
            tick <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return d[idx-1];
`ifdef UART_PARITY_EN
        else if (idx == 9) return 1'($countones(d) % 2);
`endif
        else return 1'b1;
    endfunction

    // Monitor: gathers line samples per tick and scores each finished frame.
    always @(negedge clk) begin
        if (rst) begin
            samples.delete();
            in_frame    = 1'b0;
            busy_cycles = 0;
            prev_done   = 1'b0;
        end else begin
            if (bus.tx_done) begin
                exp_t e;
                int   bad;
                logic [7:0] got;
                chk("done_single_cycle", 32'(prev_done), 0);
                chk("done_busy_low", 32'(bus.busy), 0);
                chk("done_line_high", 32'(bus.tx), 1);
                chk("done_after_frame", 32'(in_frame), 1);
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("frame_ticks", samples.size(), NBITS * TPB);
                    if (samples.size() == NBITS * TPB) begin
                        bad = -1;
                        for (int k = 0; k < NBITS * TPB; k++) begin
                            if (bad < 0 && samples[k] !== exp_bit(e.d, k / TPB)) bad = k;
                        end
                        chk("frame_tick_samples", bad, -1);
                        got = 8'h00;
                        for (int i = 0; i < 8; i++) got[i] = samples[(i + 1) * TPB + TPB / 2];
                        chk("frame_data", 32'(got), 32'(e.d));
`ifdef UART_PARITY_EN
                        chk("frame_parity", 32'(samples[9 * TPB + TPB / 2]), $countones(e.d) % 2);
`endif
                    end
                    if (e.timed) begin
                        tests++;
                        if (busy_cycles < (NBITS * TPB - 1) * COUNTER_LIMIT + 1 ||
                            busy_cycles > NBITS * TPB * COUNTER_LIMIT) begin
                            fails++;
                            $display("FAIL frame_clocks: got %0d, expected %0d..%0d",
                                     busy_cycles, (NBITS * TPB - 1) * COUNTER_LIMIT + 1,
                                     NBITS * TPB * COUNTER_LIMIT);
                        end
                    end
                end
                in_frame = 1'b0;
                samples.delete();
            end else if (!bus.busy) begin
                chk("idle_line_high", 32'(bus.tx), 1);
            end
            if (bus.busy) begin
                if (!in_frame) begin
                    in_frame    = 1'b1;
                    busy_cycles = 0;
                    samples.delete();
                end
                busy_cycles++;
                if (tick) samples.push_back(bus.tx);
            end
            prev_done = bus.tx_done;
        end
    end

    task automatic wait_idle(input string name);
        int guard = 0;
        while (bus.busy && guard < 40000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (bus.busy) chk(name, 32'(bus.busy), 0);
    endtask

    // Sends one frame; while it runs, data is disturbed and start is pulsed.
    task automatic send_frame(input logic [7:0] d, input bit timed,
                              input bit fixed_junk, input logic [7:0] junk);
        @(posedge clk); #1;
        wait_idle("send_idle_timeout");
        bus.data     = d;
        bus.tx_start = 1'b1;
        sb_q.push_back('{d, timed});
        @(posedge clk); #1;
        chk("accept_busy", 32'(bus.busy), 1);
        chk("accept_start_bit", 32'(bus.tx), 0);
        for (int g = 0; g < 40000 && bus.busy; g++) begin
            bus.data     = fixed_junk ? junk : 8'($urandom);
            bus.tx_start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.tx_start = 1'b0;
        chk("frame_end_timeout", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.data     = 8'h00;

        // Reset held ~30 ns, then idle outputs.
        #30;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_tx", 32'(bus.tx), 1);
            chk("reset_busy", 32'(bus.busy), 0);
            chk("reset_done", 32'(bus.tx_done), 0);
        end

        // Real baud divisor, 0xA5, frame duration checked.
        div = COUNTER_LIMIT;
        send_frame(8'hA5, 1'b1, 1'b1, 8'hFF);

        // Data changed to 0xFF mid-frame must not affect 0x3C.
        div = 4;
        send_frame(8'h3C, 1'b0, 1'b1, 8'hFF);
        send_frame(8'h07, 1'b0, 1'b0, 8'h00);

        // Start held high across two frames.
        @(posedge clk); #1;
        wait_idle("b2b_idle_timeout");
        bus.data     = 8'h55;
        bus.tx_start = 1'b1;
        sb_q.push_back('{8'h55, 1'b0});
        @(posedge clk); #1;
        chk("b2b_first_busy", 32'(bus.busy), 1);
        bus.data = 8'hAA;
        sb_q.push_back('{8'hAA, 1'b0});
        wait_idle("b2b_first_timeout");
        chk("b2b_done_pulse", 32'(bus.tx_done), 1);
        @(posedge clk); #1;
        chk("b2b_second_busy", 32'(bus.busy), 1);
        chk("b2b_second_start_bit", 32'(bus.tx), 0);
        bus.tx_start = 1'b0;
        wait_idle("b2b_second_timeout");

        // Reset during data bit 4 of 0xF0: frame abandoned, no done.
        @(posedge clk); #1;
        bus.data     = 8'hF0;
        bus.tx_start = 1'b1;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        for (int g = 0; g < 5000 && samples.size() < 5 * TPB + 8; g++) begin
            @(posedge clk); #1;
        end
        chk("midreset_reached_bit4", 32'(samples.size() >= 5 * TPB + 8), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_tx", 32'(bus.tx), 1);
        chk("midreset_busy", 32'(bus.busy), 0);
        chk("midreset_done", 32'(bus.tx_done), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("midreset_no_done", 32'(bus.tx_done), 0);
        end
        send_frame(8'h12, 1'b0, 1'b0, 8'h00);

        // Randomised frames with varied tick rate and idle gaps.
        for (int i = 0; i < 30; i++) begin
            div = $urandom_range(1, 4);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_frame(8'($urandom), 1'b0, 1'b0, 8'h00);
        end

        // Let the monitor score the last frame.
        for (int g = 0; g < 5000 && sb_q.size() != 0; g++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
